// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: datapath widths, ALUOp encodings and ALU control codes shared with the ALU
package id_ex_stage_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam logic [1:0] OP_LDST = 2'b00;
  localparam logic [1:0] OP_BR   = 2'b01;
  localparam logic [1:0] OP_R    = 2'b10;
  localparam logic [1:0] OP_I    = 2'b11;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_XOR  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_MUL  = 3'b101;
  localparam logic [2:0] ALU_SRAI = 3'b111;
endpackage

// File: rtl/id_ex_stage_alu_ctrl_decode.sv
// alu_ctrl_decode: maps ALUOp and {funct7,funct3} to the 3-bit ALU control code
module alu_ctrl_decode
  import id_ex_stage_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [9:0] funct,
  output logic [2:0] alu_ctrl
);
  always_comb begin
    alu_ctrl = alu_op == OP_BR ? ALU_SUB :
               alu_op == OP_R  ? (funct == 10'b0000000_111 ? ALU_AND :
                                  funct == 10'b0000000_100 ? ALU_XOR :
                                  funct == 10'b0000000_001 ? ALU_SLL :
                                  funct == 10'b0100000_000 ? ALU_SUB :
                                  funct == 10'b0000001_000 ? ALU_MUL : ALU_ADD) :
               alu_op == OP_I && funct == 10'b0100000_101 ? ALU_SRAI : ALU_ADD;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU control decode, operand forwarding and load-use detect
module id_ex_stage #(
  parameter int DATA_W = id_ex_stage_pkg::DATA_W,
  parameter int REG_AW = id_ex_stage_pkg::REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [9:0]        funct_i,
  input  logic [1:0]        alu_op_i,
  input  logic              alu_src_i,
  input  logic              reg_write_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              mem_to_reg_i,
  input  logic              exmem_wr_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_res_i,
  input  logic              memwb_wr_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_res_i,
  output logic [DATA_W-1:0] alu_data1_o,
  output logic [DATA_W-1:0] alu_data2_o,
  output logic [2:0]        alu_ctrl_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              reg_write_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              mem_to_reg_o,
  output logic              valid_o,
  output logic              load_use_o
);
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] imm;
    logic [2:0]        alu_ctrl;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } stage_t;
  stage_t q;
  logic [2:0] alu_ctrl;
  logic ex1, ex2, wb1, wb2;
  logic [DATA_W-1:0] fwd2;
  alu_ctrl_decode u_dec (.alu_op(alu_op_i), .funct(funct_i), .alu_ctrl(alu_ctrl));
  // load_use_o is already gated by stall_i, so flush or load-use both mean bubble
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) q <= '0;
    else if (flush_i || load_use_o) q <= '0;
    else if (!stall_i) q <= '{valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i, rs1_data_i, rs2_data_i,
                              imm_i, alu_ctrl, alu_src_i, reg_write_i, mem_read_i, mem_write_i,
                              mem_to_reg_i};
  assign ex1 = exmem_wr_i && exmem_rd_i != '0 && exmem_rd_i == q.rs1;
  assign ex2 = exmem_wr_i && exmem_rd_i != '0 && exmem_rd_i == q.rs2;
  assign wb1 = memwb_wr_i && memwb_rd_i != '0 && memwb_rd_i == q.rs1;
  assign wb2 = memwb_wr_i && memwb_rd_i != '0 && memwb_rd_i == q.rs2;
  assign alu_data1_o = ex1 ? exmem_res_i : wb1 ? memwb_res_i : q.d1;
  assign fwd2 = ex2 ? exmem_res_i : wb2 ? memwb_res_i : q.d2;
  assign alu_data2_o = q.alu_src ? q.imm : fwd2;
  assign store_data_o = fwd2;
  assign alu_ctrl_o = q.alu_ctrl;
  assign rd_addr_o = q.rd;
  assign reg_write_o = q.reg_write;
  assign mem_read_o = q.mem_read;
  assign mem_write_o = q.mem_write;
  assign mem_to_reg_o = q.mem_to_reg;
  assign valid_o = q.valid;
  assign load_use_o = q.valid && q.mem_read && q.rd != '0 && !stall_i &&
                      (q.rd == rs1_addr_i || q.rd == rs2_addr_i);
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of decode, forwarding, load-use, flush and async reset
module tb_id_ex_stage;
  logic clk_i = 1'b0, rst_i, stall_i, flush_i, valid_i;
  logic [4:0] rs1_addr_i, rs2_addr_i, rd_addr_i, exmem_rd_i, memwb_rd_i, rd_addr_o;
  logic [31:0] rs1_data_i, rs2_data_i, imm_i, exmem_res_i, memwb_res_i;
  logic [9:0] funct_i;
  logic [1:0] alu_op_i;
  logic alu_src_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i, exmem_wr_i, memwb_wr_i;
  logic [31:0] alu_data1_o, alu_data2_o, store_data_o;
  logic [2:0] alu_ctrl_o;
  logic reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o, load_use_o;
  int checks = 0, failures = 0;
  typedef struct {
    logic [1:0] op;
    logic [9:0] f;
    logic       src;
    logic [2:0] exp;
  } dec_t;
  dec_t tbl [11];

  id_ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .funct_i(funct_i),
    .alu_op_i(alu_op_i), .alu_src_i(alu_src_i), .reg_write_i(reg_write_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
    .exmem_wr_i(exmem_wr_i), .exmem_rd_i(exmem_rd_i), .exmem_res_i(exmem_res_i),
    .memwb_wr_i(memwb_wr_i), .memwb_rd_i(memwb_rd_i), .memwb_res_i(memwb_res_i),
    .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
    .store_data_o(store_data_o), .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o),
    .valid_o(valid_o), .load_use_o(load_use_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    tbl[0]  = '{2'b10, 10'b0100000_000, 1'b0, 3'b100};
    tbl[1]  = '{2'b10, 10'b0000001_000, 1'b0, 3'b101};
    tbl[2]  = '{2'b11, 10'b0100000_101, 1'b1, 3'b111};
    tbl[3]  = '{2'b01, 10'b0000000_000, 1'b0, 3'b100};
    tbl[4]  = '{2'b00, 10'b0000000_010, 1'b1, 3'b011};
    tbl[5]  = '{2'b10, 10'b0000000_010, 1'b0, 3'b011};
    tbl[6]  = '{2'b10, 10'b0000000_111, 1'b0, 3'b000};
    tbl[7]  = '{2'b10, 10'b0000000_100, 1'b0, 3'b001};
    tbl[8]  = '{2'b10, 10'b0000000_001, 1'b0, 3'b010};
    tbl[9]  = '{2'b11, 10'b1111111_000, 1'b1, 3'b011};
    tbl[10] = '{2'b11, 10'b0000000_101, 1'b1, 3'b011};
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    rs1_addr_i = '0; rs2_addr_i = '0; rd_addr_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    imm_i = '0; funct_i = '0; alu_op_i = '0; alu_src_i = 1'b0; reg_write_i = 1'b0;
    mem_read_i = 1'b0; mem_write_i = 1'b0; mem_to_reg_i = 1'b0;
    exmem_wr_i = 1'b0; exmem_rd_i = '0; exmem_res_i = '0;
    memwb_wr_i = 1'b0; memwb_rd_i = '0; memwb_res_i = '0;
    #12;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_ctrl", 32'(alu_ctrl_o), 32'd0);
    check("rst_data1", alu_data1_o, 32'd0);
    check("rst_rd", 32'(rd_addr_o), 32'd0);
    check("rst_lu", 32'(load_use_o), 32'd0);
    rst_i = 1'b0;
    // add x3,x1,x2
    valid_i = 1'b1; rs1_addr_i = 5'd1; rs2_addr_i = 5'd2; rd_addr_i = 5'd3;
    rs1_data_i = 32'd5; rs2_data_i = 32'd7; imm_i = 32'h99; funct_i = 10'b0000000_000;
    alu_op_i = 2'b10; reg_write_i = 1'b1;
    check("pre_load_valid", 32'(valid_o), 32'd0);
    step();
    check("add_ctrl", 32'(alu_ctrl_o), 32'd3);
    check("add_data1", alu_data1_o, 32'd5);
    check("add_data2", alu_data2_o, 32'd7);
    check("add_valid", 32'(valid_o), 32'd1);
    check("add_rd", 32'(rd_addr_o), 32'd3);
    check("add_regwr", 32'(reg_write_o), 32'd1);
    check("add_store", store_data_o, 32'd7);
    for (int i = 0; i < 11; i++) begin
      alu_op_i = tbl[i].op; funct_i = tbl[i].f; alu_src_i = tbl[i].src;
      step();
      check($sformatf("dec%0d_ctrl", i), 32'(alu_ctrl_o), 32'(tbl[i].exp));
      check($sformatf("dec%0d_data2", i), alu_data2_o, tbl[i].src ? 32'h99 : 32'd7);
    end
    // forwarding, rs1=x4
    alu_op_i = 2'b10; funct_i = '0; alu_src_i = 1'b0;
    rs1_addr_i = 5'd4; rs1_data_i = 32'h1111;
    exmem_wr_i = 1'b1; exmem_rd_i = 5'd4; exmem_res_i = 32'hAAAA;
    memwb_wr_i = 1'b1; memwb_rd_i = 5'd4; memwb_res_i = 32'hBBBB;
    step();
    check("fwd_both", alu_data1_o, 32'hAAAA);
    check("fwd_rs2_none", alu_data2_o, 32'd7);
    exmem_rd_i = 5'd0; #1;
    check("fwd_wb_only", alu_data1_o, 32'hBBBB);
    memwb_rd_i = 5'd0; #1;
    check("fwd_rd0", alu_data1_o, 32'h1111);
    memwb_rd_i = 5'd2; #1;
    check("fwd_wb_rs2", alu_data2_o, 32'hBBBB);
    check("fwd_wb_store", store_data_o, 32'hBBBB);
    exmem_wr_i = 1'b0; memwb_wr_i = 1'b0; #1;
    check("fwd_off_rs2", store_data_o, 32'd7);
    // lw x6
    rs1_addr_i = 5'd1; rs1_data_i = 32'd5; rs2_addr_i = 5'd0; rd_addr_i = 5'd6;
    alu_op_i = 2'b00; mem_read_i = 1'b1; mem_to_reg_i = 1'b1; alu_src_i = 1'b1;
    step();
    check("lw_memrd", 32'(mem_read_o), 32'd1);
    check("lw_m2r", 32'(mem_to_reg_o), 32'd1);
    check("lw_ctrl", 32'(alu_ctrl_o), 32'd3);
    rs2_addr_i = 5'd6; rd_addr_i = 5'd7; alu_op_i = 2'b10; mem_read_i = 1'b0;
    mem_to_reg_i = 1'b0; alu_src_i = 1'b0; #1;
    check("lu_detect", 32'(load_use_o), 32'd1);
    stall_i = 1'b1; #1;
    check("lu_stall_mask", 32'(load_use_o), 32'd0);
    step();
    check("stall_hold_rd", 32'(rd_addr_o), 32'd6);
    check("stall_hold_memrd", 32'(mem_read_o), 32'd1);
    check("stall_hold_valid", 32'(valid_o), 32'd1);
    stall_i = 1'b0; #1;
    check("lu_again", 32'(load_use_o), 32'd1);
    step();
    check("bubble_valid", 32'(valid_o), 32'd0);
    check("bubble_regwr", 32'(reg_write_o), 32'd0);
    check("bubble_rd", 32'(rd_addr_o), 32'd0);
    check("bubble_lu", 32'(load_use_o), 32'd0);
    step();
    check("after_bubble_rd", 32'(rd_addr_o), 32'd7);
    check("after_bubble_valid", 32'(valid_o), 32'd1);
    // flush beats stall
    rd_addr_i = 5'd9; mem_write_i = 1'b1; flush_i = 1'b1; stall_i = 1'b1;
    step();
    check("flush_valid", 32'(valid_o), 32'd0);
    check("flush_rd", 32'(rd_addr_o), 32'd0);
    check("flush_regwr", 32'(reg_write_o), 32'd0);
    check("flush_memwr", 32'(mem_write_o), 32'd0);
    check("flush_data1", alu_data1_o, 32'd0);
    check("flush_store", store_data_o, 32'd0);
    flush_i = 1'b0; stall_i = 1'b0; mem_write_i = 1'b0;
    step();
    check("reload_rd", 32'(rd_addr_o), 32'd9);
    #2 rst_i = 1'b1;
    #1;
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_rd", 32'(rd_addr_o), 32'd0);
    check("arst_data1", alu_data1_o, 32'd0);
    check("arst_regwr", 32'(reg_write_o), 32'd0);
    #1 rst_i = 1'b0;
    step();
    check("post_rst_valid", 32'(valid_o), 32'd1);
    check("post_rst_rd", 32'(rd_addr_o), 32'd9);
    check("post_rst_data1", alu_data1_o, 32'd5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
